// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C transmit byte sequencer.
package i2c_seq_pkg;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic ACK_OK        = 1'b0;
  localparam logic ACK_NACK      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_ACK,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; decrements saturate at zero.
module seq_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/i2c_tx_byte_sequencer.sv
// Sequences multi-byte I2C transmits: fetch byte, load holding register,
// start the bit engine, count bit strobes, then act on the slave ACK.
module i2c_tx_byte_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DATA_W = BITS_PER_BYTE,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              abort,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_load,
  output logic              byte_start,
  input  logic              bit_done,
  input  logic              ack_valid,
  input  logic              ack_bit,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic [CNT_W-1:0]  bytes_left
);

  localparam int             BCW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  seq_state_t        state_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              hold_load_q;
  logic              byte_start_q;
  logic              done_q;
  logic              busy_q;
  logic              nack_q;
  logic [BCW-1:0]    bit_cnt_q;

  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic              bit_hit;
  logic              ack_last;

  always_comb begin
    cnt_load = (state_q == ST_IDLE) && start && (byte_count != '0);
    cnt_dec  = (state_q == ST_ACK) && !abort && ack_valid && (ack_bit == ACK_OK);
    // A strobe in the byte_start cycle belongs to the previous byte's timing.
    bit_hit  = (state_q == ST_SEND) && bit_done && !byte_start_q;
    ack_last = cnt_zero || (cnt_val == CNT_W'(1));
  end

  seq_down_counter #(
    .CNT_W (CNT_W)
  ) u_bytes_left (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (cnt_load),
    .load_val_i (byte_count),
    .dec_i      (cnt_dec),
    .count_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      hold_data_q  <= '0;
      hold_load_q  <= 1'b0;
      byte_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      nack_q       <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      hold_load_q  <= 1'b0;
      byte_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              nack_q <= 1'b0;
              busy_q <= 1'b1;
              if (byte_count != '0) begin
                state_q <= ST_FETCH;
              end else begin
                state_q <= ST_FINISH;
                done_q  <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            if (tx_valid) begin
              hold_data_q <= tx_data;
              hold_load_q <= 1'b1;
              state_q     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            byte_start_q <= 1'b1;
            state_q      <= ST_SEND;
          end
          ST_SEND: begin
            if (bit_hit) begin
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                state_q   <= ST_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + BCW'(1);
              end
            end
          end
          ST_ACK: begin
            if (ack_valid) begin
              if (ack_bit == ACK_NACK) begin
                nack_q  <= 1'b1;
                state_q <= ST_FINISH;
                done_q  <= 1'b1;
              end else if (ack_last) begin
                state_q <= ST_FINISH;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_FETCH;
              end
            end
          end
          ST_FINISH: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready   = (state_q == ST_FETCH);
  assign hold_data  = hold_data_q;
  assign hold_load  = hold_load_q;
  assign byte_start = byte_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack       = nack_q;
  assign bytes_left = cnt_val;

endmodule
